io_peripherals: RTL and testbench

//  Peripheral bank directly downstream of the I/O address decoder: consumes its one-hot io_enable.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_debounce.sv | 47 ++++
 rtl/io_peripherals.sv | 93 +++++++++
 tb/tb_io_peripherals.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the I/O decoder and the peripheral bank.
package io_pkg;

  localparam int unsigned IO_LED_BIT = 0;
  localparam int unsigned IO_SW_BIT  = 1;
  localparam int unsigned IO_BTN_BIT = 2;

  localparam int unsigned IO_ADDR_LED = 32;
  localparam int unsigned IO_ADDR_SW  = 33;
  localparam int unsigned IO_ADDR_BTN = 34;

  typedef logic [2:0] io_en_t;

endpackage

// File: rtl/io_debounce.sv
// One-bit 2-FF synchroniser followed by a counting debouncer.
// deb follows the synchronised pin only after DB_CYCLES consecutive mismatching cycles.
module io_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic deb,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mismatch;
  logic             w_expire;

  assign w_mismatch = r_sync2 ^ deb;
  assign w_expire   = w_mismatch && (r_cnt == CNT_W'(DB_CYCLES - 1));

  // Counter runs only while the synchronised pin disagrees with deb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      deb     <= 1'b0;
      rise    <= 1'b0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
      rise    <= w_expire & r_sync2;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_cnt <= '0;
        deb   <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_peripherals.sv
// LED register, debounced switch/button inputs and CPU read mux.
// Define IO_BTN_LATCH_EN to read buttons as read-to-clear sticky press flags.
module io_peripherals
  import io_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_LEDS    = 16,
  parameter int unsigned N_SW      = 16,
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  io_en_t            io_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [N_LEDS-1:0] leds_out,
  output logic [DATA_W-1:0] r_data
);

  logic [N_SW-1:0]  w_sw_deb;
  logic [N_SW-1:0]  w_unused_sw_rise;
  logic [N_BTN-1:0] w_btn_deb;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] w_btn_word;
  logic             w_unused_wdata;

  // Only the low N_LEDS bits of store data reach the LEDs.
  assign w_unused_wdata = ^w_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_out <= '0;
    end else if (io_enable[IO_LED_BIT]) begin
      leds_out <= w_data[N_LEDS-1:0];
    end
  end

  for (genvar i = 0; i < int'(N_SW); i++) begin : g_sw
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (sw_in[i]),
      .deb    (w_sw_deb[i]),
      .rise   (w_unused_sw_rise[i])
    );
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (btn_in[i]),
      .deb    (w_btn_deb[i]),
      .rise   (w_btn_rise[i])
    );
  end

`ifdef IO_BTN_LATCH_EN
  logic [N_BTN-1:0] r_btn_flag;
  logic             w_unused_btn_deb;

  assign w_unused_btn_deb = ^w_btn_deb;

  // A new press in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_flag <= '0;
    end else begin
      r_btn_flag <= (r_btn_flag & ~{N_BTN{io_enable[IO_BTN_BIT]}}) | w_btn_rise;
    end
  end

  assign w_btn_word = r_btn_flag;
`else
  logic w_unused_btn_rise;

  assign w_unused_btn_rise = ^w_btn_rise;
  assign w_btn_word        = w_btn_deb;
`endif

  // Switch read outranks button read on an illegal multi-hot enable.
  always_comb begin
    r_data = '0;
    if (io_enable[IO_SW_BIT]) begin
      r_data[N_SW-1:0] = w_sw_deb;
    end else if (io_enable[IO_BTN_BIT]) begin
      r_data[N_BTN-1:0] = w_btn_word;
    end
  end

endmodule

// File: tb/tb_io_peripherals.sv
// Self-checking bench for io_peripherals with DB_CYCLES=4.
// Define IO_BTN_LATCH_EN to exercise the sticky button flags instead of button level.
module tb_io_peripherals;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned N_LEDS    = 16;
  localparam int unsigned N_SW      = 16;
  localparam int unsigned N_BTN     = 4;
  localparam int unsigned DB_CYCLES = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        io_enable;
  logic [DATA_W-1:0] w_data;
  logic [N_SW-1:0]   sw_in;
  logic [N_BTN-1:0]  btn_in;
  logic [N_LEDS-1:0] leds_out;
  logic [DATA_W-1:0] r_data;

  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  io_peripherals #(
    .DATA_W    (DATA_W),
    .N_LEDS    (N_LEDS),
    .N_SW      (N_SW),
    .N_BTN     (N_BTN),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_enable (io_enable),
    .w_data    (w_data),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .leds_out  (leds_out),
    .r_data    (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n     = 1'b0;
    io_enable = 3'($urandom);
    w_data    = $urandom;
    sw_in     = N_SW'($urandom);
    btn_in    = N_BTN'($urandom);
    #2;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({16'h0, leds_out} !== 32'h0 || r_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: leds_out=%h r_data=%h required 0/0", i, leds_out, r_data);
      end
      if (i < 3) begin
        tick();
        io_enable = 3'($urandom);
        w_data    = $urandom;
        sw_in     = N_SW'($urandom);
        btn_in    = N_BTN'($urandom);
      end
    end
    rst_n     = 1'b1;
    io_enable = 3'b000;
    sw_in     = '0;
    btn_in    = '0;
    repeat (8) exp_q.push_back(32'h0);
    while (exp_q.size() > 0) begin
      tick();
      w_data = $urandom;
      exp    = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp || leds_out !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle: r_data=%h leds_out=%h required %h/0000", r_data, leds_out, exp);
      end
    end
  endtask

  task automatic test_led_write();
    logic [31:0] exp;
    io_enable = 3'b001;
    w_data    = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0000_BEEF);
    tick();
    exp = exp_q.pop_front();
    n_tests++;
    if ({16'h0, leds_out} !== exp) begin
      n_fail++;
      $display("FAIL led_write: leds_out=%h required %h", leds_out, exp[15:0]);
    end
    io_enable = 3'b000;
    repeat (5) exp_q.push_back(32'h0000_BEEF);
    while (exp_q.size() > 0) begin
      w_data = $urandom;
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if ({16'h0, leds_out} !== exp) begin
        n_fail++;
        $display("FAIL led_hold: leds_out=%h required %h", leds_out, exp[15:0]);
      end
    end
  endtask

  task automatic test_sw_debounce();
    logic [31:0] exp;
    io_enable = 3'b010;
    sw_in     = 16'h0008;
    repeat (DB_CYCLES + 1) exp_q.push_back(32'h0);
    exp_q.push_back(32'h8);
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp) begin
        n_fail++;
        $display("FAIL sw_latency: r_data=%h required %h", r_data, exp);
      end
    end
    sw_in = 16'h0028;
    repeat (3) exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp) begin
        n_fail++;
        $display("FAIL sw_glitch_on: r_data=%h required %h", r_data, exp);
      end
    end
    sw_in = 16'h0008;
    repeat (8) exp_q.push_back(32'h8);
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp) begin
        n_fail++;
        $display("FAIL sw_glitch_off: r_data=%h required %h", r_data, exp);
      end
    end
  endtask

`ifndef IO_BTN_LATCH_EN
  task automatic test_btn_level();
    logic [31:0] exp;
    io_enable = 3'b100;
    btn_in    = 4'b0010;
    repeat (DB_CYCLES + 1) exp_q.push_back(32'h0);
    repeat (4) exp_q.push_back(32'h2);
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp) begin
        n_fail++;
        $display("FAIL btn_level_press: r_data=%h required %h", r_data, exp);
      end
    end
    btn_in = 4'b0000;
    repeat (DB_CYCLES + 1) exp_q.push_back(32'h2);
    repeat (3) exp_q.push_back(32'h0);
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp) begin
        n_fail++;
        $display("FAIL btn_level_release: r_data=%h required %h", r_data, exp);
      end
    end
    io_enable = 3'b110;
    btn_in    = 4'b0000;
    #1;
    n_tests++;
    if (r_data !== 32'h8) begin
      n_fail++;
      $display("FAIL multi_hot_read: r_data=%h required %h", r_data, 32'h8);
    end
    io_enable = 3'b000;
  endtask
`else
  task automatic test_btn_sticky();
    logic [31:0] exp;
    io_enable = 3'b000;
    btn_in    = 4'b0001;
    repeat (DB_CYCLES + 4) tick();
    btn_in = 4'b0000;
    repeat (DB_CYCLES + 4) tick();
    io_enable = 3'b100;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp) begin
      n_fail++;
      $display("FAIL sticky_read: r_data=%h required %h", r_data, exp);
    end
    tick();
    exp = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp) begin
      n_fail++;
      $display("FAIL sticky_clear: r_data=%h required %h", r_data, exp);
    end
    io_enable = 3'b000;
    tick();
    // deb rises DB_CYCLES+2 edges after the pin; read while the rise pulse is live.
    btn_in = 4'b0001;
    repeat (DB_CYCLES + 2) tick();
    io_enable = 3'b100;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp) begin
      n_fail++;
      $display("FAIL sticky_coincide_read: r_data=%h required %h", r_data, exp);
    end
    tick();
    exp = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp) begin
      n_fail++;
      $display("FAIL sticky_set_wins: r_data=%h required %h", r_data, exp);
    end
    tick();
    io_enable = 3'b000;
    btn_in    = 4'b0000;
    repeat (DB_CYCLES + 4) tick();
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] exp;
    io_enable = 3'b001;
    w_data    = 32'h0000_1234;
    tick();
    io_enable = 3'b010;
    sw_in     = 16'h0002;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (leds_out !== 16'h0 || r_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: leds_out=%h r_data=%h required 0000/0", leds_out, r_data);
    end
    tick();
    rst_n = 1'b1;
    repeat (DB_CYCLES + 1) exp_q.push_back(32'h0);
    repeat (3) exp_q.push_back(32'h2);
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (r_data !== exp || leds_out !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_recount: r_data=%h leds_out=%h required %h/0000", r_data, leds_out, exp);
      end
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    io_enable = 3'b000;
    w_data    = '0;
    sw_in     = '0;
    btn_in    = '0;
    test_reset();
    test_led_write();
    test_sw_debounce();
`ifndef IO_BTN_LATCH_EN
    test_btn_level();
`else
    test_btn_sticky();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
